exec_unit: RTL and testbench
============================

# exec_unit

Multi-cycle execute stage that sits directly downstream of the 16×16-bit register file. It consumes the two read-port operands (A, B), performs the selected ALU or multiply operation, and drives the register file's write port (C, Caddr, load) to write the result back. Single-cycle ops complete in two cycles. MUL is an iterative 16-step shift-add unit.

## Interface
- WIDTH, 16, datapath width (operands, result)
- AW, 4, register address width
- clk  in  1  rising-edge clock, shared with the register file
- nClear  in  1  synchronous active-low reset, shared with the register file
- start  in  1  request; sampled only when busy=0
- op  in  3  operation select (see Operation)
- A  in  WIDTH  operand A, from register file port A
- B  in  WIDTH  operand B, from register file port B
- dest  in  AW  destination register address
- busy  out  1  high while an operation is in progress, including the WB cycle
- done  out  1  one-cycle pulse in the WB cycle
- C  out  WIDTH  result, to register file write data
- Caddr  out  AW  write address, to register file
- load  out  1  write enable to register file; active-high, exactly one cycle per operation
- zero  out  1  result == 0, updated with C
- carry  out  1  ADD carry-out / SUB borrow; 0 for all other ops

## Operation
- Opcodes:
  - 000 ADD: A+B
  - 001 SUB: A−B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL: A << B[3:0], zero-fill
  - 110 SHR: A >> B[3:0], logical
  - 111 MUL: low WIDTH bits of unsigned A×B
- All arithmetic is modulo 2^WIDTH and unsigned.
  - SUB borrow: carry=1 iff A<B.
  - Shift amount 0 returns A unchanged. B[15:4] is ignored for shifts.
- States:
  - IDLE → EXEC when start=1 and op≠111.
  - IDLE → MUL when start=1 and op=111.
  - EXEC → WB.
  - MUL → WB after 16 iterations.
  - WB → IDLE.
- On the accepting edge, latch A, B, op and dest into internal registers. Later changes on A/B/dest have no effect.
- MUL:
  - Multiplicand and multiplier are held in shift registers, with a 4-bit iteration counter running 0..15.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right.
- C, Caddr, zero and carry are registered when the state enters WB. They hold their value until the next WB.
- load and done are high only in WB.
- start while busy=1 is ignored; no queuing.
- nClear=0 at any rising edge, including mid-MUL:
  - Next state is IDLE.
  - C=0, Caddr=0, zero=0, carry=0, busy=0, done=0, load=0.
  - No write is issued for the aborted operation.
- Reset values: all outputs 0.

## Timing
- Cycle numbering: start is high in cycle 0 and sampled at the edge that ends cycle 0.
- Single-cycle ops:
  - Cycle 1: EXEC, busy=1.
  - Cycle 2: WB, load=done=busy=1, with C/Caddr valid.
  - Cycle 3: IDLE. A new start is accepted if presented in cycle 3.
- MUL:
  - Cycles 1..16: MUL, busy=1.
  - Cycle 17: WB.
  - Cycle 18: IDLE.
- Back-to-back operation: start held high continuously issues a new op every 3 cycles (non-MUL).
- The register file captures C at the edge ending the WB cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset: hold nClear=0 for 2 cycles with start=1 → busy, done, load, C, Caddr, zero and carry all 0, and no write occurs.
- ADD: A=0xFFFF, B=0x0002, dest=3 → cycle 2 shows load=1, C=0x0001, Caddr=3, carry=1, zero=0. Cycle 3 shows load=0 with C still 0x0001.
- SUB:
  - A=5, B=5, dest=7 → C=0x0000, zero=1, carry=0.
  - A=3, B=4 → C=0xFFFF, carry=1.
- MUL:
  - A=0x0123, B=0x0010, dest=9 → busy high for cycles 1–17, load only in cycle 17, C=0x1230.
  - A=0xFFFF, B=0xFFFF → C=0x0001.
- Shift and ignored start:
  - SHL with A=0x8001, B=0x0011 → C=0x0002.
  - Pulse start in cycle 1 with op=ADD → ignored; exactly one load pulse is seen.
  - SHR with A=0x8000, B=0x000F → C=0x0001.
- Abort: nClear=0 in MUL cycle 8 → IDLE in the next cycle and load is never asserted. A following ADD with A=1, B=1, dest=2 gives C=0x0002 in its cycle 2.

Source files
------------

// File: rtl/exec_unit.sv
// Multi-cycle execute stage: ALU ops in EXEC, iterative shift-add MUL,
// single write-back cycle that drives the register file write port.
module exec_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             nClear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [AW-1:0]    dest,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C,
  output logic [AW-1:0]    Caddr,
  output logic             load,
  output logic             zero,
  output logic             carry
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t state, state_d;

  // Latched operands; during MUL a_q is the multiplicand and b_q the multiplier
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [2:0]       op_q;
  logic [AW-1:0]    dest_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] acc_nxt, res;
  logic             res_carry;
  logic             busy_d, wb_d, cap;

  // State register
  always_ff @(posedge clk) begin
    if (!nClear) state <= S_IDLE;
    else         state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (start) state_d = (op == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC: state_d = S_WB;
      S_MUL:  if (cnt_q == CW'(WIDTH - 1)) state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result selection: ALU in EXEC, final accumulator step in MUL
  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = {1'b0, a_q} - {1'b0, b_q};
    acc_nxt   = acc_q + ({WIDTH{b_q[0]}} & a_q);
    res       = '0;
    res_carry = 1'b0;
    if (state == S_MUL) begin
      res = acc_nxt;
    end else begin
      case (op_q)
        OP_ADD: begin res = sum[WIDTH-1:0];  res_carry = sum[WIDTH];  end
        OP_SUB: begin res = diff[WIDTH-1:0]; res_carry = diff[WIDTH]; end
        OP_AND: res = a_q & b_q;
        OP_OR:  res = a_q | b_q;
        OP_XOR: res = a_q ^ b_q;
        OP_SHL: res = a_q << b_q[3:0];
        OP_SHR: res = a_q >> b_q[3:0];
        default: res = '0;
      endcase
    end
  end

  // Output decode from the upcoming state so every output is a flop
  always_comb begin
    busy_d = (state_d != S_IDLE);
    wb_d   = (state_d == S_WB);
    cap    = wb_d && (state != S_WB);
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!nClear) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      load  <= 1'b0;
      C     <= '0;
      Caddr <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= wb_d;
      load <= wb_d;
      if (cap) begin
        C     <= res;
        Caddr <= dest_q;
        zero  <= (res == '0);
        carry <= res_carry;
      end
    end
  end

  // Operand capture and shift-add iteration
  always_ff @(posedge clk) begin
    if (!nClear) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      op_q   <= OP_ADD;
      dest_q <= '0;
      cnt_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q    <= A;
            b_q    <= B;
            op_q   <= op;
            dest_q <= dest;
            acc_q  <= '0;
            cnt_q  <= '0;
          end
        end
        S_MUL: begin
          acc_q <= acc_nxt;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: expected write-backs are queued at issue
// and popped when load is observed.
module tb_exec_unit;

  logic        clk, nClear, start;
  logic [2:0]  op;
  logic [15:0] A, B;
  logic [3:0]  dest;
  logic        busy, done, load, zero, carry;
  logic [15:0] C;
  logic [3:0]  Caddr;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;

  typedef struct packed {
    logic [15:0] c;
    logic [3:0]  a;
    logic        z;
    logic        cy;
  } exp_t;

  exp_t exp_q[$];

  exec_unit #(.WIDTH(16), .AW(4)) dut (
    .clk(clk), .nClear(nClear), .start(start), .op(op), .A(A), .B(B),
    .dest(dest), .busy(busy), .done(done), .C(C), .Caddr(Caddr),
    .load(load), .zero(zero), .carry(carry)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (load === 1'b1) load_cnt++;

  function automatic exp_t model(input logic [2:0] o, input logic [15:0] a,
                                 input logic [15:0] b, input logic [3:0] d);
    exp_t e;
    logic [16:0] w;
    logic [31:0] p;
    logic [3:0]  sh;
    sh   = b[3:0];
    e.a  = d;
    e.cy = 1'b0;
    case (o)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; e.c = w[15:0]; e.cy = w[16]; end
      3'd1: begin e.c = a - b; e.cy = (a < b); end
      3'd2: e.c = a & b;
      3'd3: e.c = a | b;
      3'd4: e.c = a ^ b;
      3'd5: e.c = a << sh;
      3'd6: e.c = a >> sh;
      default: begin p = {16'h0, a} * {16'h0, b}; e.c = p[15:0]; end
    endcase
    e.z = (e.c == 16'h0);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] d);
    start = 1'b1; op = o; A = a; B = b; dest = d;
    exp_q.push_back(model(o, a, b, d));
  endtask

  // Called in cycle 1; returns the cycle number in which load is seen, -1 on timeout
  task automatic wait_load(output int cyc);
    cyc = 1;
    while (load !== 1'b1 && cyc < 40) begin
      tick;
      cyc++;
    end
    if (load !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset;
    int lc0;
    nClear = 1'b0; start = 1'b1; op = 3'd0; A = 16'h1; B = 16'h1; dest = 4'h5;
    lc0 = load_cnt;
    tick; tick;
    checks++;
    if ({busy, done, load, C, Caddr, zero, carry} !== 26'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {busy, done, load, C, Caddr, zero, carry});
    end
    checks++;
    if (load_cnt != lc0) begin
      errors++;
      $display("FAIL reset_no_write: loads %0d want 0", load_cnt - lc0);
    end
    nClear = 1'b1; start = 1'b0;
    tick;
  endtask

  task automatic test_add;
    exp_t e;
    issue(3'd0, 16'hFFFF, 16'h0002, 4'd3);
    tick; start = 1'b0;
    checks++;
    if ({busy, load, done} !== 3'b100) begin
      errors++;
      $display("FAIL add_cycle1: busy/load/done %b want 100", {busy, load, done});
    end
    tick;
    checks++;
    if ({busy, load, done} !== 3'b111) begin
      errors++;
      $display("FAIL add_cycle2_strobes: busy/load/done %b want 111", {busy, load, done});
    end
    e = exp_q.pop_front();
    checks++;
    if ({C, Caddr, zero, carry} !== e) begin
      errors++;
      $display("FAIL add_result: got %h want %h", {C, Caddr, zero, carry}, e);
    end
    tick;
    checks++;
    if (load !== 1'b0 || busy !== 1'b0 || C !== 16'h0001) begin
      errors++;
      $display("FAIL add_cycle3_hold: load %b busy %b C %h want 0 0 0001", load, busy, C);
    end
  endtask

  task automatic test_sub;
    exp_t e;
    int cyc;
    issue(3'd1, 16'd5, 16'd5, 4'd7);
    tick; start = 1'b0;
    wait_load(cyc);
    checks++;
    if (cyc != 2) begin
      errors++;
      $display("FAIL sub_eq_latency: cycle %0d want 2", cyc);
    end
    e = exp_q.pop_front();
    checks++;
    if ({C, Caddr, zero, carry} !== e) begin
      errors++;
      $display("FAIL sub_eq_result: got %h want %h", {C, Caddr, zero, carry}, e);
    end
    tick;
    issue(3'd1, 16'd3, 16'd4, 4'd8);
    tick; start = 1'b0;
    wait_load(cyc);
    e = exp_q.pop_front();
    checks++;
    if (cyc != 2 || {C, Caddr, zero, carry} !== e) begin
      errors++;
      $display("FAIL sub_borrow: cycle %0d got %h want cycle 2 %h", cyc, {C, Caddr, zero, carry}, e);
    end
    tick;
  endtask

  task automatic test_mul;
    exp_t e;
    int cyc;
    int bad;
    issue(3'd7, 16'h0123, 16'h0010, 4'd9);
    tick; start = 1'b0;
    bad = 0;
    for (int c = 1; c <= 17; c++) begin
      if (busy !== 1'b1) bad++;
      if (load !== (c == 17)) bad++;
      if (c < 17) tick;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mul_busy_load_window: %0d bad cycles want 0", bad);
    end
    e = exp_q.pop_front();
    checks++;
    if ({C, Caddr, zero, carry} !== e) begin
      errors++;
      $display("FAIL mul_result: got %h want %h", {C, Caddr, zero, carry}, e);
    end
    tick;
    checks++;
    if (busy !== 1'b0 || load !== 1'b0) begin
      errors++;
      $display("FAIL mul_cycle18_idle: busy %b load %b want 0 0", busy, load);
    end
    issue(3'd7, 16'hFFFF, 16'hFFFF, 4'd10);
    tick; start = 1'b0;
    wait_load(cyc);
    e = exp_q.pop_front();
    checks++;
    if (cyc != 17 || {C, Caddr, zero, carry} !== e) begin
      errors++;
      $display("FAIL mul_max: cycle %0d got %h want cycle 17 %h", cyc, {C, Caddr, zero, carry}, e);
    end
    tick;
  endtask

  task automatic test_shift_ignored;
    exp_t e;
    int cyc;
    int lc0;
    lc0 = load_cnt;
    issue(3'd5, 16'h8001, 16'h0011, 4'd1);
    tick;
    start = 1'b1; op = 3'd0; A = 16'h1111; B = 16'h2222; dest = 4'd15;
    tick; start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (load !== 1'b1 || {C, Caddr, zero, carry} !== e) begin
      errors++;
      $display("FAIL shl_result: load %b got %h want 1 %h", load, {C, Caddr, zero, carry}, e);
    end
    repeat (6) tick;
    checks++;
    if (load_cnt - lc0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start: loads %0d busy %b want 1 0", load_cnt - lc0, busy);
    end
    issue(3'd6, 16'h8000, 16'h000F, 4'd4);
    tick; start = 1'b0;
    wait_load(cyc);
    e = exp_q.pop_front();
    checks++;
    if (cyc != 2 || {C, Caddr, zero, carry} !== e) begin
      errors++;
      $display("FAIL shr_result: cycle %0d got %h want cycle 2 %h", cyc, {C, Caddr, zero, carry}, e);
    end
    tick;
    issue(3'd5, 16'h1234, 16'hFFF0, 4'd6);
    tick; start = 1'b0;
    wait_load(cyc);
    e = exp_q.pop_front();
    checks++;
    if (cyc != 2 || {C, Caddr, zero, carry} !== e) begin
      errors++;
      $display("FAIL shl_zero_amount: cycle %0d got %h want cycle 2 %h", cyc, {C, Caddr, zero, carry}, e);
    end
    tick;
  endtask

  task automatic test_abort;
    exp_t e;
    int cyc;
    int lc0;
    lc0 = load_cnt;
    issue(3'd7, 16'h00FF, 16'h0101, 4'd11);
    tick; start = 1'b0;
    repeat (7) tick;
    nClear = 1'b0;
    tick;
    nClear = 1'b1;
    void'(exp_q.pop_back());
    checks++;
    if ({busy, done, load, C, Caddr, zero, carry} !== 26'h0) begin
      errors++;
      $display("FAIL abort_idle: got %h want 0", {busy, done, load, C, Caddr, zero, carry});
    end
    repeat (20) tick;
    checks++;
    if (load_cnt != lc0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_write: loads %0d busy %b want 0 0", load_cnt - lc0, busy);
    end
    issue(3'd0, 16'd1, 16'd1, 4'd2);
    tick; start = 1'b0;
    wait_load(cyc);
    e = exp_q.pop_front();
    checks++;
    if (cyc != 2 || {C, Caddr, zero, carry} !== e) begin
      errors++;
      $display("FAIL abort_then_add: cycle %0d got %h want cycle 2 %h", cyc, {C, Caddr, zero, carry}, e);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [2:0] ops [4];
    logic [2:0] o;
    logic [15:0] a, b;
    ops[0] = 3'd0; ops[1] = 3'd3; ops[2] = 3'd4; ops[3] = 3'd1;
    for (int k = 0; k < 12; k++) begin
      o = ops[k / 3];
      a = 16'($urandom);
      b = 16'($urandom);
      start = 1'b1; op = o; A = a; B = b; dest = 4'(k);
      if (k % 3 == 0) exp_q.push_back(model(o, a, b, 4'(k)));
      checks++;
      if (load !== (k % 3 == 2)) begin
        errors++;
        $display("FAIL b2b_load_cycle%0d: load %b want %b", k, load, (k % 3 == 2));
      end
      if (load === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({C, Caddr, zero, carry} !== e) begin
          errors++;
          $display("FAIL b2b_result_cycle%0d: got %h want %h", k, {C, Caddr, zero, carry}, e);
        end
      end
      tick;
    end
    start = 1'b0;
    repeat (3) tick;
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: busy %b pending %0d want 0 0", busy, exp_q.size());
    end
  endtask

  initial begin
    nClear = 1'b0; start = 1'b0; op = 3'd0; A = 16'h0; B = 16'h0; dest = 4'h0;
    test_reset;
    test_add;
    test_sub;
    test_mul;
    test_shift_ignored;
    test_abort;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
